// File: rtl/hps_stream_source_pkg.sv
// Shared definitions for the HPS stream source: default widths and FSM state encoding.
package hps_stream_source_pkg;

   localparam int HPS_IN_WIDTH  = 32;
   localparam int HPS_MAG_WIDTH = 96;
   localparam int HPS_K_WIDTH   = 11;

   localparam logic [1:0] ST_FILL   = 2'd0;
   localparam logic [1:0] ST_CLEAR  = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

endpackage

// File: rtl/hps_stream_source_spectrum_ram.sv
// Spectrum RAM: one write port, one registered read port, 2**ADDR_W words of WIDTH bits.
module spectrum_ram #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 11
) (
   input  logic              clock,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]  i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WIDTH-1:0]  o_rd_data
);

   logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
   logic [WIDTH-1:0] r_rd_data;

   // NOTE: the array has no reset so it maps onto block RAM; contents persist across frames and resets.
   always_ff @(posedge clock) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/hps_stream_source.sv
// Harmonic product spectrum source: buffers one FFT frame, then streams mag[k]*mag[2k]*mag[3k] for k=0..N-1.
module hps_stream_source
   import hps_stream_source_pkg::*;
#(
   parameter int IN_WIDTH  = HPS_IN_WIDTH,
   parameter int MAG_WIDTH = HPS_MAG_WIDTH,
   parameter int K_WIDTH   = HPS_K_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [IN_WIDTH-1:0]  in_mag,
   input  logic [K_WIDTH-1:0]   in_k,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic                 frame_clear_n,
   output logic                 out_valid,
   output logic [MAG_WIDTH-1:0] out_mag,
   output logic [K_WIDTH-1:0]   out_k
);

   localparam logic [K_WIDTH-1:0] K_LAST = {K_WIDTH{1'b1}};

   logic [1:0]            r_state;
   logic [1:0]            w_state_next;
   logic [K_WIDTH-1:0]    r_k;
   logic [K_WIDTH:0]      w_k2;
   logic [K_WIDTH+1:0]    w_k3;
   logic                  w_k2_oor;
   logic                  w_k3_oor;
   logic                  w_wr_en;
   logic                  w_rd_en;
   logic [IN_WIDTH-1:0]   w_mag_a;
   logic [IN_WIDTH-1:0]   w_mag_b;
   logic [IN_WIDTH-1:0]   w_mag_c;
   logic [IN_WIDTH-1:0]   w_b;
   logic [IN_WIDTH-1:0]   w_c;

   logic                  r_rd_valid;
   logic [K_WIDTH-1:0]    r_rd_k;
   logic                  r_rd_z2;
   logic                  r_rd_z3;
   logic [2*IN_WIDTH-1:0] r_ab;
   logic [IN_WIDTH-1:0]   r_c;
   logic                  r_ab_valid;
   logic [K_WIDTH-1:0]    r_ab_k;
   logic                  r_out_valid;
   logic [MAG_WIDTH-1:0]  r_out_mag;
   logic [K_WIDTH-1:0]    r_out_k;

   // Harmonic addresses are widened so an out-of-range harmonic is flagged rather than wrapped.
   assign w_k2     = {r_k, 1'b0};
   assign w_k3     = {1'b0, w_k2} + {2'b00, r_k};
   assign w_k2_oor = w_k2[K_WIDTH];
   assign w_k3_oor = |w_k3[K_WIDTH+1:K_WIDTH];

   assign w_wr_en = in_valid && (r_state == ST_FILL);
   assign w_rd_en = (r_state == ST_STREAM);

   spectrum_ram #(.WIDTH(IN_WIDTH), .ADDR_W(K_WIDTH)) u_ram_a (
      .clock     (clock),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (in_k),
      .i_wr_data (in_mag),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (r_k),
      .o_rd_data (w_mag_a)
   );

   spectrum_ram #(.WIDTH(IN_WIDTH), .ADDR_W(K_WIDTH)) u_ram_b (
      .clock     (clock),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (in_k),
      .i_wr_data (in_mag),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_k2[K_WIDTH-1:0]),
      .o_rd_data (w_mag_b)
   );

   spectrum_ram #(.WIDTH(IN_WIDTH), .ADDR_W(K_WIDTH)) u_ram_c (
      .clock     (clock),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (in_k),
      .i_wr_data (in_mag),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_k3[K_WIDTH-1:0]),
      .o_rd_data (w_mag_c)
   );

   assign w_b = r_rd_z2 ? '0 : w_mag_b;
   assign w_c = r_rd_z3 ? '0 : w_mag_c;

   // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_FILL:   if (in_valid && in_last) w_state_next = ST_CLEAR;
         ST_CLEAR:  w_state_next = ST_STREAM;
         ST_STREAM: if (r_k == K_LAST) w_state_next = ST_DRAIN;
         ST_DRAIN:  if (r_out_valid && (r_out_k == K_LAST)) w_state_next = ST_FILL;
         default:   w_state_next = ST_FILL;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_FILL;
         r_k         <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_k      <= '0;
         r_rd_z2     <= 1'b0;
         r_rd_z3     <= 1'b0;
         r_ab        <= '0;
         r_c         <= '0;
         r_ab_valid  <= 1'b0;
         r_ab_k      <= '0;
         r_out_valid <= 1'b0;
         r_out_mag   <= '0;
         r_out_k     <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_STREAM) r_k <= r_k + K_WIDTH'(1);

         r_rd_valid <= w_rd_en;
         r_rd_k     <= r_k;
         r_rd_z2    <= w_k2_oor;
         r_rd_z3    <= w_k3_oor;

         r_ab_valid <= r_rd_valid;
         r_ab_k     <= r_rd_k;
         if (r_rd_valid) begin
            r_ab <= {{IN_WIDTH{1'b0}}, w_mag_a} * {{IN_WIDTH{1'b0}}, w_b};
            r_c  <= w_c;
         end

         r_out_valid <= r_ab_valid;
         r_out_k     <= r_ab_k;
         if (r_ab_valid)
            r_out_mag <= {{(MAG_WIDTH-2*IN_WIDTH){1'b0}}, r_ab} *
                         {{(MAG_WIDTH-IN_WIDTH){1'b0}}, r_c};
      end
   end

   assign in_ready      = (r_state == ST_FILL);
   assign frame_clear_n = (r_state != ST_CLEAR);
   assign out_valid     = r_out_valid;
   assign out_mag       = r_out_mag;
   assign out_k         = r_out_k;

endmodule

// File: doc/hps_stream_source.md
HPS_STREAM_SOURCE -- requirements
Module: hps_stream_source

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: bit width of each FFT magnitude input.
REQ-002 SHALL have parameter MAG_WIDTH, default 96: output product width; equals 3*IN_WIDTH.
REQ-003 SHALL have parameter K_WIDTH, default 11: bin index width; N = 2^K_WIDTH bins.
REQ-004 SHALL have port clock  input  1  sole clock, all state on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input bin present.
REQ-007 SHALL have port in_mag  input  IN_WIDTH  unsigned FFT magnitude.
REQ-008 SHALL have port in_k  input  K_WIDTH  bin index of in_mag, used as write address.
REQ-009 SHALL have port in_last  input  1  marks the final bin of a frame.
REQ-010 SHALL have port in_ready  output  1  high only in FILL; bins with in_valid while in_ready=0 are dropped.
REQ-011 SHALL have port frame_clear_n  output  1  active-low one-cycle clear for the downstream maximum tracker's reset_n.
REQ-012 SHALL have port out_valid  output  1  out_mag/out_k valid.
REQ-013 SHALL have port out_mag  output  MAG_WIDTH  HPS product for out_k.
REQ-014 SHALL have port out_k  output  K_WIDTH  bin index, strictly increasing 0..N-1 within a frame.

Function
REQ-015 SHALL implement FSM states FILL, CLEAR, STREAM, DRAIN.
REQ-016 In FILL, each in_valid cycle SHALL write in_mag to all three RAM copies at in_k; in_valid&&in_last SHALL transition to CLEAR next edge (last bin still written).
REQ-017 CLEAR SHALL last exactly one cycle with frame_clear_n=0, then go to STREAM.
REQ-018 STREAM SHALL issue one read per cycle for k=0..N-1 (counter k, addresses k, 2k, 3k), N consecutive cycles, then go to DRAIN.
REQ-019 2k and 3k SHALL be computed at K_WIDTH+1 and K_WIDTH+2 bits; any address > N-1 SHALL force its factor to 0 via a flag pipelined with the read, never wrapping.
REQ-020 Pipeline SHALL be: RAM read (1 cycle), a*b registered (2*IN_WIDTH bits), (a*b)*c registered (MAG_WIDTH bits); latency from read issue to out_valid exactly 3 cycles, no truncation.
REQ-021 out_valid SHALL be high for exactly N consecutive cycles per frame; out_k travels with the data.
REQ-022 DRAIN SHALL return to FILL on the cycle after out_k=N-1 is presented; in_ready re-asserts in that FILL cycle.
REQ-023 Bins not written in a frame SHALL retain the previous frame's RAM contents; RAM is not cleared.
REQ-024 k=0 SHALL produce mag[0]^3.

Reset
REQ-025 Asserting reset SHALL immediately force state FILL, k=0, out_valid=0, out_mag=0, out_k=0, frame_clear_n=1, in_ready=1, pipeline valids 0, including mid-STREAM.
REQ-026 RAM contents SHALL be unaffected by reset.

Structure
REQ-027 IN_WIDTH, MAG_WIDTH, K_WIDTH defaults and the FSM state encoding SHALL live in the shared HPS package.
REQ-028 SHALL instantiate sub-module spectrum_ram (1 write port, 1 registered read port, N x IN_WIDTH) three times.

Verification (bench K_WIDTH=4, N=16)
REQ-029 All 16 mags=1, in_last on k=15 -> out_mag=1 for k=0..5, 0 for k=6..15.
REQ-030 mag[k]=k+1 -> out_k=2 gives 3*5*7=105; out_k=5 gives 6*11*16=1056.
REQ-031 All mags=0xFFFFFFFF -> out_k=0 gives (2^32-1)^3, full 96 bits exact.
REQ-032 Timing: frame_clear_n low exactly 1 cycle; first out_valid (k=0) on the 4th edge after the edge that lowered frame_clear_n; 16 contiguous valids; in_valid pulses during STREAM have no effect on RAM (next frame unchanged).
REQ-033 Reset asserted while out_k=7 -> out_valid=0 without a clock edge; after release in_ready=1; a refilled frame streams all 16 bins correctly.
REQ-034 Second frame writing only k=0..7 -> bins 8..15 use first-frame values.
